// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: instruction-memory read sequencer.
// Paces fetches by tick or single step and hands each word to the consumer.
module im_fetch_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int TICK_DIV  = 250000,
    parameter int LAST_ADDR = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              mode,
    input  logic              step,
    input  logic              in_ok,
    input  logic              data_ack,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              data_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ,
        PRESENT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [ADDR_W-1:0] addr_n;

    // Next state, tick counter and address; halt overrides everything.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = rd_addr;
        if (halt) begin
            state_n = IDLE;
            cnt_n   = '0;
            addr_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_n = WAIT;
                        cnt_n   = '0;
                        addr_n  = '0;
                    end
                end
                WAIT: begin
                    if (!mode) begin
                        if (in_ok) begin
                            if (cnt == CNT_LAST) begin
                                state_n = READ;
                                cnt_n   = '0;
                            end else begin
                                cnt_n = cnt + CNT_W'(1);
                            end
                        end
                    end else if (step && in_ok) begin
                        state_n = READ;
                    end
                end
                READ: begin
                    state_n = PRESENT;
                end
                PRESENT: begin
                    if (data_ack) begin
                        if (rd_addr == ADDR_LAST) begin
                            state_n = DONE;
                        end else begin
                            state_n = WAIT;
                            cnt_n   = '0;
                            addr_n  = rd_addr + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State register with outputs decoded from the next state so all are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_addr    <= '0;
            rd_en      <= 1'b0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rd_addr    <= addr_n;
            rd_en      <= (state_n == READ);
            data_valid <= (state_n == PRESENT);
            busy       <= (state_n != IDLE);
            done       <= (state_n == DONE);
        end
    end

endmodule
